gan_host_seq: RTL and testbench

Host-side sequencer for the GAN core (`top_level`), driving the opposite end of the core's interface. It accepts a request containing two Q8.24 operands and a mode bit, then drives `choice`, `in_1` and `in_2` into the core. It waits for `gen_finish` or `disc_finish` and returns the result. Generator results come back as a handshaked 9-pixel stream; discriminator results come back as a one-cycle score pulse with a real/fake decision.

---
 rtl/gan_pkg.sv | 20 ++
 rtl/pixel_stream_buf.sv | 72 +++++++
 rtl/gan_host_seq.sv | 148 ++++++++++++++
 tb/tb_gan_host_seq.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gan_pkg.sv
// Shared definitions for the GAN host sequencer.
//   Q8.24 constants used when interpreting core scores.
//   PIX_COUNT: pixels per generator result (3x3 image).
//   seq_state_e: sequencer state encoding.
package gan_pkg;

  localparam logic [31:0] Q_ONE  = 32'h0100_0000;
  localparam logic [31:0] Q_ZERO = 32'h0000_0000;
  localparam logic [31:0] Q_HALF = 32'h0080_0000;

  localparam int unsigned PIX_COUNT = 9;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StStream,
    StResult
  } seq_state_e;

endpackage

// File: rtl/pixel_stream_buf.sv
// Nine-entry pixel buffer with a valid/ready output stream.
//   i_load     : capture all pixels from i_pix_bus (pixel 0 in the LSBs).
//   i_start    : begin streaming from index 0.
//   i_ready    : consumer ready.
//   o_valid    : stream active.
//   o_data     : buffer[o_idx] while active, 0 otherwise.
//   o_idx      : current pixel index 0..PIX_COUNT-1.
//   o_last     : current pixel is the final one.
//   o_done     : handshake of the final pixel this cycle.
module pixel_stream_buf
  import gan_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_load,
  input  logic                       i_start,
  input  logic [PIX_COUNT*WIDTH-1:0] i_pix_bus,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [3:0]                 o_idx,
  output logic                       o_last,
  output logic                       o_done
);

  localparam logic [3:0] LastIdx = 4'(PIX_COUNT - 1);

  logic [WIDTH-1:0] r_buf [PIX_COUNT];
  logic             r_active;
  logic [3:0]       r_idx;
  logic             w_fire;
  logic             w_at_last;

  assign w_fire    = r_active && i_ready;
  assign w_at_last = (r_idx == LastIdx);

  assign o_valid = r_active;
  assign o_data  = r_active ? r_buf[r_idx] : '0;
  assign o_idx   = r_idx;
  assign o_last  = r_active && w_at_last;
  assign o_done  = w_fire && w_at_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_idx    <= '0;
      for (int k = 0; k < PIX_COUNT; k++) begin
        r_buf[k] <= '0;
      end
    end else begin
      if (i_load) begin
        for (int k = 0; k < PIX_COUNT; k++) begin
          r_buf[k] <= i_pix_bus[k*WIDTH +: WIDTH];
        end
      end
      if (i_start) begin
        r_active <= 1'b1;
        r_idx    <= '0;
      end else if (w_fire) begin
        if (w_at_last) begin
          r_active <= 1'b0;
          r_idx    <= '0;
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/gan_host_seq.sv
// Host-side sequencer for the GAN core.
//   Request side : i_req_valid/o_req_ready handshake with mode and two Q8.24 operands.
//   Core side    : o_choice/o_in_1/o_in_2 driven to the core; i_gen_finish/i_disc_finish,
//                  i_out_discriminator and i_pix_bus returned from it.
//   Results      : generator pixels as a valid/ready stream (o_pix_*), discriminator
//                  score as a one-cycle pulse (o_disc_*).
//   Status       : o_busy outside IDLE; o_timeout_err sticky until the next accept.
module gan_host_seq
  import gan_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_mode,
  input  logic [WIDTH-1:0]           i_req_in_1,
  input  logic [WIDTH-1:0]           i_req_in_2,
  output logic                       o_choice,
  output logic [WIDTH-1:0]           o_in_1,
  output logic [WIDTH-1:0]           o_in_2,
  input  logic                       i_gen_finish,
  input  logic                       i_disc_finish,
  input  logic [WIDTH-1:0]           i_out_discriminator,
  input  logic [PIX_COUNT*WIDTH-1:0] i_pix_bus,
  output logic                       o_pix_valid,
  input  logic                       i_pix_ready,
  output logic [WIDTH-1:0]           o_pix_data,
  output logic [3:0]                 o_pix_idx,
  output logic                       o_pix_last,
  output logic                       o_disc_valid,
  output logic [WIDTH-1:0]           o_disc_data,
  output logic                       o_disc_real,
  output logic                       o_busy,
  output logic                       o_timeout_err
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] QHalfW = WIDTH'(Q_HALF);

  seq_state_e       r_state, w_state_d;
  logic             r_choice;
  logic [WIDTH-1:0] r_in_1, r_in_2;
  logic [WIDTH-1:0] r_disc_data;
  logic             r_disc_real;
  logic             r_timeout_err;
  logic [CntW-1:0]  r_wait_cnt;

  logic w_accept, w_load, w_take_disc, w_timeout, w_pix_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_take_disc = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_accept  = 1'b1;
          w_state_d = StWait;
        end
      end
      StWait: begin
        // The matching finish is checked first so it beats an expiring counter.
        if (r_choice && i_gen_finish) begin
          w_load    = 1'b1;
          w_state_d = StStream;
        end else if (!r_choice && i_disc_finish) begin
          w_take_disc = 1'b1;
          w_state_d   = StResult;
        end else if (r_wait_cnt == CntLast) begin
          w_timeout = 1'b1;
          w_state_d = StIdle;
        end
      end
      StStream: begin
        if (w_pix_done) w_state_d = StIdle;
      end
      StResult: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_choice      <= 1'b0;
      r_in_1        <= '0;
      r_in_2        <= '0;
      r_disc_data   <= '0;
      r_disc_real   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_choice      <= i_req_mode;
        r_in_1        <= i_req_in_1;
        r_in_2        <= i_req_in_2;
        r_timeout_err <= 1'b0;
        r_wait_cnt    <= '0;
      end else if (r_state == StWait) begin
        r_wait_cnt <= r_wait_cnt + CntW'(1);
      end
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_take_disc) begin
        r_disc_data <= i_out_discriminator;
        r_disc_real <= ($signed(i_out_discriminator) >= $signed(QHalfW));
      end
      // Operands stay on the core bus after a run; only choice is dropped.
      if ((w_state_d == StIdle) && (r_state != StIdle)) r_choice <= 1'b0;
    end
  end

  pixel_stream_buf #(
    .WIDTH(WIDTH)
  ) u_pix_buf (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .i_start   (w_load),
    .i_pix_bus (i_pix_bus),
    .i_ready   (i_pix_ready),
    .o_valid   (o_pix_valid),
    .o_data    (o_pix_data),
    .o_idx     (o_pix_idx),
    .o_last    (o_pix_last),
    .o_done    (w_pix_done)
  );

  assign o_req_ready   = (r_state == StIdle);
  assign o_busy        = (r_state != StIdle);
  assign o_choice      = r_choice;
  assign o_in_1        = r_in_1;
  assign o_in_2        = r_in_2;
  assign o_disc_valid  = (r_state == StResult);
  assign o_disc_data   = r_disc_data;
  assign o_disc_real   = r_disc_real;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_gan_host_seq.sv
// Scoreboard bench for gan_host_seq: stimulus pushes expected pixels / scores into
// queues, a negedge monitor pops and compares whenever the DUT presents a result.
module tb_gan_host_seq;

  localparam int W  = 32;
  localparam int TO = 64;
  localparam int NP = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_mode;
  logic [W-1:0]  req_in_1, req_in_2;
  logic          choice;
  logic [W-1:0]  in_1, in_2;
  logic          gen_finish, disc_finish;
  logic [W-1:0]  out_disc;
  logic [NP*W-1:0] pix_bus;
  logic          pix_valid, pix_ready, pix_last;
  logic [W-1:0]  pix_data;
  logic [3:0]    pix_idx;
  logic          disc_valid, disc_real, busy, timeout_err;
  logic [W-1:0]  disc_data;

  typedef struct { logic [W-1:0] data; int idx; } pix_t;
  typedef struct { logic [W-1:0] data; logic is_real; } disc_t;
  pix_t  pix_q[$];
  disc_t disc_q[$];

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;
  int rdy_cnt = 0;

  gan_host_seq #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_req_valid         (req_valid),
    .o_req_ready         (req_ready),
    .i_req_mode          (req_mode),
    .i_req_in_1          (req_in_1),
    .i_req_in_2          (req_in_2),
    .o_choice            (choice),
    .o_in_1              (in_1),
    .o_in_2              (in_2),
    .i_gen_finish        (gen_finish),
    .i_disc_finish       (disc_finish),
    .i_out_discriminator (out_disc),
    .i_pix_bus           (pix_bus),
    .o_pix_valid         (pix_valid),
    .i_pix_ready         (pix_ready),
    .o_pix_data          (pix_data),
    .o_pix_idx           (pix_idx),
    .o_pix_last          (pix_last),
    .o_disc_valid        (disc_valid),
    .o_disc_data         (disc_data),
    .o_disc_real         (disc_real),
    .o_busy              (busy),
    .o_timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer ready: 0 = always, 1 = pattern 1,0,0 repeating, 2 = random.
  always @(posedge clk) begin
    #1;
    rdy_cnt++;
    case (rdy_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ((rdy_cnt % 3) == 0);
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every presented pixel must equal the head of the expected stream,
  // stalled or not; it is consumed only on a handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          chk("pix_unexpected", {60'd0, pix_idx}, 64'hFFFF);
        end else begin
          chk("pix_data", pix_data, pix_q[0].data);
          chk("pix_idx", pix_idx, pix_q[0].idx);
          chk("pix_last", pix_last, (pix_q[0].idx == NP - 1));
          if (pix_ready) void'(pix_q.pop_front());
        end
      end
      if (disc_valid) begin
        if (disc_q.size() == 0) begin
          chk("disc_unexpected", disc_data, 64'hFFFF_FFFF_FFFF);
        end else begin
          disc_t e;
          e = disc_q.pop_front();
          chk("disc_data", disc_data, e.data);
          chk("disc_real", disc_real, e.is_real);
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_choice"}, choice, 0);
    chk({tag, "_in_1"}, in_1, 0);
    chk({tag, "_in_2"}, in_2, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_data"}, pix_data, 0);
    chk({tag, "_pix_idx"}, pix_idx, 0);
    chk({tag, "_pix_last"}, pix_last, 0);
    chk({tag, "_disc_valid"}, disc_valid, 0);
    chk({tag, "_disc_data"}, disc_data, 0);
    chk({tag, "_disc_real"}, disc_real, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
  endtask

  // Returns at the negedge following the accepting edge.
  task automatic send_req(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_mode  = mode;
    req_in_1  = a;
    req_in_2  = b;
    tick();
    req_valid = 1'b0;
    req_mode  = 1'($urandom_range(0, 1));
    req_in_1  = $urandom;
    req_in_2  = $urandom;
    @(negedge clk);
    chk("acc_choice", choice, mode);
    chk("acc_in_1", in_1, a);
    chk("acc_in_2", in_2, b);
    chk("acc_busy", busy, 1);
    chk("acc_req_ready", req_ready, 0);
    chk("acc_timeout_clr", timeout_err, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic issue_gen(input bit ramp);
    logic [NP*W-1:0] bus;
    pix_t p;
    for (int k = 0; k < NP; k++) begin
      p.data = ramp ? W'(k * 32'h0010_0000) : W'($urandom);
      p.idx  = k;
      bus[k*W +: W] = p.data;
      pix_q.push_back(p);
    end
    gen_finish = 1'b1;
    pix_bus    = bus;
  endtask

  task automatic issue_disc(input logic [W-1:0] score);
    disc_t e;
    e.data    = score;
    e.is_real = ($signed(score) >= $signed(32'h0080_0000));
    disc_q.push_back(e);
    disc_finish = 1'b1;
    out_disc    = score;
  endtask

  task automatic run_gen(input logic [W-1:0] a, input logic [W-1:0] b, input int delay,
                         input bit ramp);
    send_req(1'b1, a, b);
    for (int i = 0; i < delay; i++) begin
      tick();
      disc_finish = 1'($urandom_range(0, 1));
      out_disc    = $urandom;
      @(negedge clk);
      chk("gwait_choice", choice, 1);
      chk("gwait_in_1", in_1, a);
      chk("gwait_in_2", in_2, b);
      chk("gwait_pix_valid", pix_valid, 0);
    end
    tick();
    disc_finish = 1'b0;
    issue_gen(ramp);
    tick();
    gen_finish = 1'b0;
    pix_bus    = {NP{$urandom}};
    @(negedge clk);
    chk("first_pix_valid", pix_valid, 1);
    wait_idle();
    chk("gen_q_drained", pix_q.size(), 0);
    chk("gen_end_choice", choice, 0);
    chk("gen_end_in_1", in_1, a);
  endtask

  task automatic run_disc(input logic [W-1:0] a, input logic [W-1:0] b, input int delay,
                          input logic [W-1:0] score);
    send_req(1'b0, a, b);
    for (int i = 0; i < delay; i++) begin
      tick();
      gen_finish = 1'($urandom_range(0, 1));
      pix_bus    = {NP{$urandom}};
      @(negedge clk);
      chk("dwait_choice", choice, 0);
      chk("dwait_in_1", in_1, a);
      chk("dwait_in_2", in_2, b);
      chk("dwait_disc_valid", disc_valid, 0);
    end
    tick();
    gen_finish = 1'b0;
    issue_disc(score);
    tick();
    disc_finish = 1'b0;
    out_disc    = $urandom;
    @(negedge clk);
    chk("disc_pulse", disc_valid, 1);
    chk("disc_no_timeout", timeout_err, 0);
    tick();
    @(negedge clk);
    chk("disc_one_cycle", disc_valid, 0);
    chk("disc_end_busy", busy, 0);
    chk("disc_hold", disc_data, score);
    chk("disc_q_drained", disc_q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick_score();
    case ($urandom_range(0, 5))
      0:       return 32'h0080_0000;
      1:       return 32'h007F_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b1;  // must be ignored while in reset
    req_mode = 1'b1;
    req_in_1 = 32'h1234_5678;
    req_in_2 = 32'h9ABC_DEF0;
    gen_finish = 1'b0;
    disc_finish = 1'b0;
    out_disc = '0;
    pix_bus = '0;
    pix_ready = 1'b1;

    tick();
    tick();
    @(negedge clk);
    check_reset("reset");
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_req_ignored", busy, 0);

    // Directed generator run with ramp pixels.
    run_gen(32'h0000_0000, 32'h0100_0000, 5, 1'b1);

    // Discriminator runs either side of the decision threshold.
    run_disc(32'h0100_0000, 32'h0000_0000, 3, 32'h00C0_0000);
    run_disc(32'h0100_0000, 32'h0000_0000, 2, 32'hFF80_0000);

    // Mode 1 with only disc_finish: times out after TO cycles.
    send_req(1'b1, 32'h0000_1111, 32'h0000_2222);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      disc_finish = 1'b1;
      out_disc    = $urandom;
    end
    @(negedge clk);
    chk("to_not_yet", timeout_err, 0);
    chk("to_still_busy", busy, 1);
    tick();
    disc_finish = 1'b0;
    @(negedge clk);
    chk("to_err_set", timeout_err, 1);
    chk("to_idle", busy, 0);
    chk("to_choice", choice, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("to_sticky", timeout_err, 1);
    run_disc(32'h0000_0005, 32'h0000_0006, 1, 32'h0080_0000);

    // Backpressure 1,0,0 pattern.
    rdy_mode = 1;
    run_gen(32'h0000_00AA, 32'h0000_00BB, 2, 1'b0);
    rdy_mode = 0;

    // Reset in the middle of a stream at pixel 4.
    send_req(1'b1, 32'h0101_0101, 32'h0202_0202);
    tick();
    issue_gen(1'b0);
    tick();
    gen_finish = 1'b0;
    n = 0;
    while (pix_idx != 4'd4 && n < 20) begin
      tick();
      n++;
    end
    chk("rst_at_idx4", pix_idx, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pix_q.delete();
    @(negedge clk);
    check_reset("midrst");
    run_disc(32'h0100_0000, 32'h0000_0000, 4, 32'h0000_0001);

    // Matching finish on the expiry cycle wins (both modes).
    send_req(1'b0, 32'h0000_0777, 32'h0000_0888);
    repeat (TO - 1) tick();
    issue_disc(32'h0123_4567);
    tick();
    disc_finish = 1'b0;
    @(negedge clk);
    chk("race_disc_valid", disc_valid, 1);
    chk("race_disc_no_to", timeout_err, 0);
    tick();
    @(negedge clk);
    chk("race_disc_after", timeout_err, 0);
    send_req(1'b1, 32'h0000_0999, 32'h0000_0AAA);
    repeat (TO - 1) tick();
    issue_gen(1'b0);
    tick();
    gen_finish = 1'b0;
    @(negedge clk);
    chk("race_gen_valid", pix_valid, 1);
    chk("race_gen_no_to", timeout_err, 0);
    wait_idle();
    chk("race_gen_drained", pix_q.size(), 0);
    chk("race_gen_after", timeout_err, 0);

    // Randomized traffic.
    for (int t = 0; t < 16; t++) begin
      rdy_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 1) == 1)
        run_gen(W'($urandom), W'($urandom), $urandom_range(0, 10), 1'b0);
      else
        run_disc(W'($urandom), W'($urandom), $urandom_range(0, 10), pick_score());
    end
    rdy_mode = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
